// File: rtl/cla_pkg.sv
// Shared width and operand type for the 5-bit carry-lookahead adder.
package cla_pkg;
    localparam int CLA_W = 5;
    typedef logic [CLA_W-1:0] operand_t;
endpackage

// File: rtl/cla5_pipelined_if.sv
// Operand/result bundle for the pipelined CLA; master drives operands.
interface cla5_pipelined_if;
    import cla_pkg::*;
    operand_t A_in;
    operand_t B_in;
    logic     Cin_in;
    operand_t S_out;
    logic     Cout_out;

    modport master (
        output A_in, B_in, Cin_in,
        input  S_out, Cout_out
    );
    modport slave (
        input  A_in, B_in, Cin_in,
        output S_out, Cout_out
    );
endinterface

// File: rtl/cla5_lookahead.sv
// Combinational lookahead carries, each expanded to sum-of-products
// so no carry depends on another carry.
module cla5_lookahead
    import cla_pkg::*;
(
    input  operand_t   p,
    input  operand_t   g,
    input  logic       cin,
    output logic [5:1] c
);
    always_comb begin
        c[1] = g[0]
             | (p[0] & cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        c[5] = g[4]
             | (p[4] & g[3])
             | (p[4] & p[3] & g[2])
             | (p[4] & p[3] & p[2] & g[1])
             | (p[4] & p[3] & p[2] & p[1] & g[0])
             | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);
    end
endmodule

// File: rtl/cla5_pipelined.sv
// Three-stage pipelined 5-bit CLA: operand regs, P/G regs, sum regs.
// Results appear two edges after the operands are sampled.
module cla5_pipelined
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    cla5_pipelined_if.slave  bus
);
    operand_t   a_q;
    operand_t   b_q;
    logic       cin1_q;
    operand_t   p_q;
    operand_t   g_q;
    logic       cin2_q;
    logic [5:1] c;
    operand_t   s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            cin1_q <= 1'b0;
        end else begin
            a_q    <= bus.A_in;
            b_q    <= bus.B_in;
            cin1_q <= bus.Cin_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q    <= '0;
            g_q    <= '0;
            cin2_q <= 1'b0;
        end else begin
            p_q    <= a_q ^ b_q;
            g_q    <= a_q & b_q;
            cin2_q <= cin1_q;
        end
    end

    cla5_lookahead u_lookahead (
        .p   (p_q),
        .g   (g_q),
        .cin (cin2_q),
        .c   (c)
    );

    // Carry into bit i is cin for i=0, c[i] otherwise.
    assign s = p_q ^ {c[4:1], cin2_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.S_out    <= '0;
            bus.Cout_out <= 1'b0;
        end else begin
            bus.S_out    <= s;
            bus.Cout_out <= c[5];
        end
    end
endmodule

// File: tb/tb_cla5_pipelined.sv
// Scoreboard bench for cla5_pipelined: expected sums queued per sampling
// edge, checked by an independent monitor two edges later.
module tb_cla5_pipelined;
    import cla_pkg::*;

    typedef struct {
        int         due;
        logic [5:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   edge_no;
    int   n_checks;
    int   n_fail;
    bit   done;
    exp_t q[$];

    cla5_pipelined_if bus ();

    cla5_pipelined dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operand set (or a reset slot) and record what must come out.
    task automatic cycle(input logic [4:0] a, input logic [4:0] b,
                         input logic ci, input logic rn);
        exp_t e;
        exp_t keep[$];
        @(negedge clk);
        bus.A_in   = a;
        bus.B_in   = b;
        bus.Cin_in = ci;
        rst_n      = rn;
        @(posedge clk);
        edge_no++;
        if (!rn) begin
            keep = {};
            foreach (q[i]) if (q[i].due < edge_no) keep.push_back(q[i]);
            q = keep;
            for (int k = 0; k < 3; k++) begin
                e.due = edge_no + k;
                e.val = 6'd0;
                q.push_back(e);
            end
        end else begin
            e.due = edge_no + 2;
            e.val = 6'(int'(a) + int'(b) + int'(ci));
            q.push_back(e);
        end
        #1;
        bus.A_in   = 5'($urandom);
        bus.B_in   = 5'($urandom);
        bus.Cin_in = 1'($urandom);
    endtask

    // Monitor: outputs are stable at the falling edge.
    initial begin
        exp_t e;
        logic [5:0] got;
        while (!done) begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due < edge_no) begin
                e = q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL stale_expect due=%0d now=%0d required=%b",
                         e.due, edge_no, e.val);
            end else if (q.size() > 0 && q[0].due == edge_no) begin
                e   = q.pop_front();
                got = {bus.Cout_out, bus.S_out};
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL sum edge=%0d got={%b,%b} required={%b,%b}",
                             edge_no, got[5], got[4:0], e.val[5], e.val[4:0]);
                end
            end
        end
    end

    initial begin
        logic [10:0] v;
        edge_no    = 0;
        n_checks   = 0;
        n_fail     = 0;
        done       = 1'b0;
        rst_n      = 1'b0;
        bus.A_in   = '0;
        bus.B_in   = '0;
        bus.Cin_in = 1'b0;

        cycle(5'b11111, 5'b11111, 1'b1, 1'b0);
        cycle(5'b11111, 5'b11111, 1'b1, 1'b0);
        cycle(5'b11111, 5'b11111, 1'b1, 1'b1);

        repeat (4) cycle(5'b00011, 5'b00101, 1'b0, 1'b1);
        cycle(5'b11111, 5'b00111, 1'b0, 1'b1);
        cycle(5'b01010, 5'b01110, 1'b0, 1'b1);
        cycle(5'b11100, 5'b11100, 1'b1, 1'b1);
        cycle(5'b11111, 5'b00000, 1'b1, 1'b1);
        cycle(5'b11111, 5'b00000, 1'b0, 1'b1);
        cycle(5'b11111, 5'b11111, 1'b1, 1'b1);

        for (int i = 0; i < 32; i++)
            cycle(5'($urandom), 5'($urandom), 1'($urandom), 1'b1);

        for (int i = 0; i < 2048; i++) begin
            v = 11'(i);
            if (i == 1000)
                cycle(5'($urandom), 5'($urandom), 1'($urandom), 1'b0);
            cycle(v[10:6], v[5:1], v[0], 1'b1);
        end

        repeat (3) cycle(5'd0, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        done = 1'b1;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
